// File: rtl/hazard_stall_ctrl_if.sv
// ----------------------------------------------------------------------------
// hazard_stall_ctrl_if
// Bundles the pipeline-side signals seen by the hazard/stall controller.
//   master : pipeline side (drives ID/EX/MEM/WB status, receives controls)
//   slave  : controller side (receives status, drives controls)
// Signals:
//   id_rn/id_rm/id_rd, id_use_*          ID-stage source indices and read flags
//   ex_rd/mem_rd/wb_rd, *_rf_en           downstream destinations and write flags
//   ex_load, mem_req, mem_ready, br_taken pipeline status
//   cu_nop_sel, pc_ld, ifid_ld, ifid_flush, pipe_hold   pipeline controls
//   fwd_a/fwd_b/fwd_c                     operand source selects
//   bubble_cnt, timeout_err               status counters/flags
// ----------------------------------------------------------------------------
interface hazard_stall_ctrl_if #(
    parameter int REG_W = 4,
    parameter int CNT_W = 16
);
    logic [REG_W-1:0] id_rn;
    logic [REG_W-1:0] id_rm;
    logic [REG_W-1:0] id_rd;
    logic             id_use_rn;
    logic             id_use_rm;
    logic             id_use_rd;
    logic [REG_W-1:0] ex_rd;
    logic [REG_W-1:0] mem_rd;
    logic [REG_W-1:0] wb_rd;
    logic             ex_rf_en;
    logic             mem_rf_en;
    logic             wb_rf_en;
    logic             ex_load;
    logic             mem_req;
    logic             mem_ready;
    logic             br_taken;
    logic             cu_nop_sel;
    logic             pc_ld;
    logic             ifid_ld;
    logic             ifid_flush;
    logic             pipe_hold;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic [1:0]       fwd_c;
    logic [CNT_W-1:0] bubble_cnt;
    logic             timeout_err;

    modport master (
        output id_rn, id_rm, id_rd, id_use_rn, id_use_rm, id_use_rd,
        output ex_rd, mem_rd, wb_rd, ex_rf_en, mem_rf_en, wb_rf_en,
        output ex_load, mem_req, mem_ready, br_taken,
        input  cu_nop_sel, pc_ld, ifid_ld, ifid_flush, pipe_hold,
        input  fwd_a, fwd_b, fwd_c, bubble_cnt, timeout_err
    );

    modport slave (
        input  id_rn, id_rm, id_rd, id_use_rn, id_use_rm, id_use_rd,
        input  ex_rd, mem_rd, wb_rd, ex_rf_en, mem_rf_en, wb_rf_en,
        input  ex_load, mem_req, mem_ready, br_taken,
        output cu_nop_sel, pc_ld, ifid_ld, ifid_flush, pipe_hold,
        output fwd_a, fwd_b, fwd_c, bubble_cnt, timeout_err
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_stall_ctrl
// Pipeline hazard/stall controller: drives the ID bubble select, PC and IF/ID
// load enables, IF/ID flush and global pipe hold; selects operand forwarding
// sources; freezes the pipe while data memory is busy and flags a hung memory.
// Ports:
//   clk    pipeline clock
//   reset  synchronous, active-high
//   hz     hazard_stall_ctrl_if.slave (status in, controls/flags out)
// Configuration macro: HAZARD_FWD_EN
//   defined   : EX/MEM/WB forwarding enabled, only load-use stalls
//   undefined : forwarding selects tied to RF, any RAW match stalls
// All control outputs are combinational from state and inputs; bubble_cnt and
// timeout_err are registered.
// ----------------------------------------------------------------------------
module hazard_stall_ctrl #(
    parameter int REG_W       = 4,
    parameter int PC_REG      = 15,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic               clk,
    input  logic               reset,
    hazard_stall_ctrl_if.slave hz
);
    localparam int                WCNT_W    = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [REG_W-1:0]  PC_IDX    = REG_W'(PC_REG);
    localparam logic [WCNT_W-1:0] WCNT_MAX  = WCNT_W'(MEM_TIMEOUT);
    localparam logic [WCNT_W-1:0] WCNT_ZERO = {WCNT_W{1'b0}};
    localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        RST_FLUSH = 2'd0,
        RUN       = 2'd1,
        MEM_WAIT  = 2'd2,
        ERR       = 2'd3
    } state_t;

    state_t            state_r, state_nxt_s;
    logic [WCNT_W-1:0] wcnt_r, wcnt_nxt_s;
    logic [CNT_W-1:0]  bubble_cnt_r;
    logic              timeout_err_r;
    logic              err_set_s, bubble_inc_s;
    logic              ex_hit_s, mem_hit_s, wb_hit_s, data_stall_s;
    logic              run_cu_s, run_pc_s, run_ifid_s, run_flush_s;
    logic              cu_s, pc_s, ifid_s, flush_s, hold_s;
    logic [1:0]        fwd_a_s, fwd_b_s, fwd_c_s;
    logic [1:0]        fwd_a_o_s, fwd_b_o_s, fwd_c_o_s;

    // A source depends on a stage when it is really read, that stage writes
    // the same register, and the register is not the PC alias.
    function automatic logic src_match(input logic use_s, input logic [REG_W-1:0] src,
                                       input logic rf_en, input logic [REG_W-1:0] dst);
        return use_s & rf_en & (src == dst) & (src != PC_IDX);
    endfunction

    // Youngest producer wins; a load still in EX cannot supply its data yet.
    function automatic logic [1:0] fwd_sel(input logic use_s, input logic [REG_W-1:0] src,
                                           input logic ex_en, input logic [REG_W-1:0] ex_dst,
                                           input logic mem_en, input logic [REG_W-1:0] mem_dst,
                                           input logic wb_en, input logic [REG_W-1:0] wb_dst);
        logic [1:0] sel;
        if (src_match(use_s, src, ex_en, ex_dst)) begin
            sel = 2'b01;
        end else if (src_match(use_s, src, mem_en, mem_dst)) begin
            sel = 2'b10;
        end else if (src_match(use_s, src, wb_en, wb_dst)) begin
            sel = 2'b11;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // RAW detection against each downstream stage and forwarding selects.
    always_comb begin
        ex_hit_s  = src_match(hz.id_use_rn, hz.id_rn, hz.ex_rf_en, hz.ex_rd)
                  | src_match(hz.id_use_rm, hz.id_rm, hz.ex_rf_en, hz.ex_rd)
                  | src_match(hz.id_use_rd, hz.id_rd, hz.ex_rf_en, hz.ex_rd);
        mem_hit_s = src_match(hz.id_use_rn, hz.id_rn, hz.mem_rf_en, hz.mem_rd)
                  | src_match(hz.id_use_rm, hz.id_rm, hz.mem_rf_en, hz.mem_rd)
                  | src_match(hz.id_use_rd, hz.id_rd, hz.mem_rf_en, hz.mem_rd);
        wb_hit_s  = src_match(hz.id_use_rn, hz.id_rn, hz.wb_rf_en, hz.wb_rd)
                  | src_match(hz.id_use_rm, hz.id_rm, hz.wb_rf_en, hz.wb_rd)
                  | src_match(hz.id_use_rd, hz.id_rd, hz.wb_rf_en, hz.wb_rd);
`ifdef HAZARD_FWD_EN
        data_stall_s = hz.ex_load & ex_hit_s;
        fwd_a_s = fwd_sel(hz.id_use_rn, hz.id_rn, hz.ex_rf_en & ~hz.ex_load, hz.ex_rd,
                          hz.mem_rf_en, hz.mem_rd, hz.wb_rf_en, hz.wb_rd);
        fwd_b_s = fwd_sel(hz.id_use_rm, hz.id_rm, hz.ex_rf_en & ~hz.ex_load, hz.ex_rd,
                          hz.mem_rf_en, hz.mem_rd, hz.wb_rf_en, hz.wb_rd);
        fwd_c_s = fwd_sel(hz.id_use_rd, hz.id_rd, hz.ex_rf_en & ~hz.ex_load, hz.ex_rd,
                          hz.mem_rf_en, hz.mem_rd, hz.wb_rf_en, hz.wb_rd);
`else
        // Without forwarding every in-flight producer must drain to the RF.
        data_stall_s = ex_hit_s | mem_hit_s | wb_hit_s;
        fwd_a_s = 2'b00;
        fwd_b_s = 2'b00;
        fwd_c_s = 2'b00;
`endif
    end

    // Normal-issue decode, shared by RUN and the memory-release cycle.
    always_comb begin
        run_cu_s    = 1'b0;
        run_pc_s    = 1'b0;
        run_ifid_s  = 1'b0;
        run_flush_s = 1'b0;
        if (data_stall_s) begin
            // Bubble into EX; PC and IF/ID hold so a coincident branch re-resolves.
            run_cu_s = 1'b1;
        end else if (hz.br_taken) begin
            run_pc_s    = 1'b1;
            run_ifid_s  = 1'b1;
            run_flush_s = 1'b1;
        end else begin
            run_pc_s   = 1'b1;
            run_ifid_s = 1'b1;
        end
    end

    // Next-state, wait counter and control outputs.
    always_comb begin
        state_nxt_s  = state_r;
        wcnt_nxt_s   = wcnt_r;
        err_set_s    = 1'b0;
        bubble_inc_s = 1'b0;
        cu_s         = 1'b0;
        pc_s         = 1'b0;
        ifid_s       = 1'b0;
        flush_s      = 1'b0;
        hold_s       = 1'b0;
        fwd_a_o_s    = fwd_a_s;
        fwd_b_o_s    = fwd_b_s;
        fwd_c_o_s    = fwd_c_s;
        case (state_r)
            RST_FLUSH: begin
                cu_s        = 1'b1;
                flush_s     = 1'b1;
                fwd_a_o_s   = 2'b00;
                fwd_b_o_s   = 2'b00;
                fwd_c_o_s   = 2'b00;
                wcnt_nxt_s  = WCNT_ZERO;
                state_nxt_s = RUN;
            end
            RUN: begin
                if (hz.mem_req & ~hz.mem_ready) begin
                    hold_s      = 1'b1;
                    wcnt_nxt_s  = WCNT_ONE;
                    state_nxt_s = MEM_WAIT;
                end else begin
                    cu_s         = run_cu_s;
                    pc_s         = run_pc_s;
                    ifid_s       = run_ifid_s;
                    flush_s      = run_flush_s;
                    bubble_inc_s = run_cu_s;
                    wcnt_nxt_s   = WCNT_ZERO;
                end
            end
            MEM_WAIT: begin
                if (hz.mem_ready) begin
                    // Release in the same cycle with an ordinary issue decision.
                    cu_s         = run_cu_s;
                    pc_s         = run_pc_s;
                    ifid_s       = run_ifid_s;
                    flush_s      = run_flush_s;
                    bubble_inc_s = run_cu_s;
                    wcnt_nxt_s   = WCNT_ZERO;
                    state_nxt_s  = RUN;
                end else begin
                    hold_s = 1'b1;
                    if (wcnt_r == WCNT_MAX) begin
                        err_set_s   = 1'b1;
                        state_nxt_s = ERR;
                    end else begin
                        wcnt_nxt_s = wcnt_r + WCNT_ONE;
                    end
                end
            end
            ERR: begin
                hold_s = 1'b1;
                cu_s   = 1'b1;
            end
            default: begin
                wcnt_nxt_s  = WCNT_ZERO;
                state_nxt_s = RST_FLUSH;
            end
        endcase
    end

    // State, wait counter, saturating bubble counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= RST_FLUSH;
            wcnt_r        <= WCNT_ZERO;
            bubble_cnt_r  <= CNT_ZERO;
            timeout_err_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            wcnt_r  <= wcnt_nxt_s;
            if (bubble_inc_s && (bubble_cnt_r != CNT_MAX)) begin
                bubble_cnt_r <= bubble_cnt_r + CNT_ONE;
            end
            if (err_set_s) begin
                timeout_err_r <= 1'b1;
            end
        end
    end

    assign hz.cu_nop_sel  = cu_s;
    assign hz.pc_ld       = pc_s;
    assign hz.ifid_ld     = ifid_s;
    assign hz.ifid_flush  = flush_s;
    assign hz.pipe_hold   = hold_s;
    assign hz.fwd_a       = fwd_a_o_s;
    assign hz.fwd_b       = fwd_b_o_s;
    assign hz.fwd_c       = fwd_c_o_s;
    assign hz.bubble_cnt  = bubble_cnt_r;
    assign hz.timeout_err = timeout_err_r;
endmodule
